// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin mux-select arbiter.
package arb_pkg;

  localparam int ARB_NUM_REQ = 4;
  localparam int ARB_SEL_W   = 2;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  function automatic logic [ARB_NUM_REQ-1:0] onehot_of(input logic [ARB_SEL_W-1:0] idx);
    onehot_of = {{(ARB_NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority scan over four requests, starting at ptr and wrapping 3->0.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [ARB_NUM_REQ-1:0] req,
  input  logic [ARB_SEL_W-1:0]   ptr,
  output logic                   found,
  output logic [ARB_SEL_W-1:0]   idx
);

  logic [ARB_SEL_W-1:0] cand;

  // Walk offsets from farthest to nearest so the lowest offset from ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = ARB_NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + ARB_SEL_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter owning a shared 4:1 mux select, with bounded hold and a dead cycle between grants.
// Optional ARB_LOCK_EN adds a lock input that suppresses hold-limit expiry while the owner keeps requesting.
//
// state     | meaning
// ARB_IDLE  | no grant; pick next requester from ptr
// ARB_GRANT | one requester owns the mux; select frozen
module rr_mux_sel_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ARB_NUM_REQ-1:0] req,
`ifdef ARB_LOCK_EN
  input  logic                   lock,
`endif
  output logic [ARB_SEL_W-1:0]   select,
  output logic [ARB_NUM_REQ-1:0] gnt,
  output logic                   busy
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  arb_state_t            state_q;
  logic [ARB_SEL_W-1:0]  sel_q;
  logic [ARB_SEL_W-1:0]  ptr_q;
  logic [ARB_NUM_REQ-1:0] gnt_q;
  logic                  busy_q;
  logic [HOLD_W-1:0]     hold_q;
  logic [HOLD_W-1:0]     hold_d;
  logic                  expired;
  logic                  rel;
  logic                  pick_found;
  logic [ARB_SEL_W-1:0]  pick_idx;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Counter saturates so a locked grant can sit at the limit indefinitely.
  always_comb begin
    hold_d  = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
    expired = (hold_q == HOLD_MAX);
`ifdef ARB_LOCK_EN
    if (lock) expired = 1'b0;
`endif
    rel = !req[sel_q] || expired;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_found) begin
            state_q <= ARB_GRANT;
            sel_q   <= pick_idx;
            gnt_q   <= onehot_of(pick_idx);
            busy_q  <= 1'b1;
            hold_q  <= HOLD_W'(1);
          end
        end
        ARB_GRANT: begin
          if (rel) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= sel_q + ARB_SEL_W'(1);
          end else begin
            hold_q  <= hold_d;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign select = sel_q;
  assign gnt    = gnt_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// Self-checking bench for rr_mux_sel_arbiter against a rule-level reference model.
module tb_rr_mux_sel_arbiter;

  localparam int MAXH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       lock = 1'b0;
  logic [1:0] select;
  logic [3:0] gnt;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Reference model: current owner (-1 none), cycles owned, rotation start, last select.
  int m_cur = -1;
  int m_dur = 0;
  int m_ptr = 0;
  int m_sel = 0;

  rr_mux_sel_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
`ifdef ARB_LOCK_EN
    .lock   (lock),
`endif
    .select (select),
    .gnt    (gnt),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_gnt();
    return (m_cur < 0) ? 4'b0000 : 4'(1 << m_cur);
  endfunction

  function automatic logic m_lock_on();
`ifdef ARB_LOCK_EN
    return lock;
`else
    return 1'b0;
`endif
  endfunction

  // Apply one clock edge to the model with the inputs the DUT samples, then settle.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_cur = -1; m_ptr = 0; m_sel = 0; m_dur = 0;
    end else if (m_cur < 0) begin
      for (int o = 0; o < 4; o++) begin
        if (req[(m_ptr + o) % 4]) begin
          m_cur = (m_ptr + o) % 4; m_sel = m_cur; m_dur = 1;
          break;
        end
      end
    end else if (!req[m_cur] || (m_dur >= MAXH && !m_lock_on())) begin
      m_cur = -1;
      m_ptr = (m_sel + 1) % 4;
    end else if (m_dur < MAXH) begin
      m_dur++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; lock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (gnt !== 4'b0000 || select !== 2'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc %0d gnt %b sel %0d busy %b want 0000 0 0", i, gnt, select, busy);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0001 || select !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_grant gnt %b sel %0d busy %b want 0001 0 1", gnt, select, busy);
    end
  endtask

  task automatic test_single();
    int zeros = 0;
    rst = 1'b1; req = 4'b0100; tick(); rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt == 4'b0000) zeros++;
      checks++;
      if (gnt !== m_gnt() || select !== 2'(m_sel) || busy !== (m_cur >= 0) || select !== 2'd2) begin
        errors++;
        $display("FAIL single cyc %0d gnt %b/%b sel %0d/2 busy %b", i, gnt, m_gnt(), select, busy);
      end
    end
    // 20 cycles: 8 on, 1 off, 8 on, 1 off, 2 on
    checks++;
    if (zeros != 2) begin
      errors++;
      $display("FAIL single_gaps got %0d want 2", zeros);
    end
  endtask

  task automatic test_full_load();
    int order[$];
    logic [3:0] prev = 4'b0000;
    rst = 1'b1; req = 4'b1111; tick(); rst = 1'b0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (gnt != 4'b0000 && prev == 4'b0000) order.push_back(int'(select));
      prev = gnt;
      checks++;
      if (gnt !== m_gnt() || select !== 2'(m_sel) || busy !== (m_cur >= 0)) begin
        errors++;
        $display("FAIL full_load cyc %0d gnt %b/%b sel %0d/%0d", i, gnt, m_gnt(), select, m_sel);
      end
    end
    checks++;
    if (order.size() != 5 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3 || order[4] != 0) begin
      errors++;
      $display("FAIL full_load_order got %p want 0 1 2 3 0", order);
    end
  endtask

  task automatic test_early_release();
    rst = 1'b1; req = 4'b0000; tick(); rst = 1'b0;
    req = 4'b1001; tick(); tick(); tick();
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL early_grant0 gnt %b want 0001", gnt); end
    req = 4'b1000; tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL early_drop gnt %b want 0000", gnt); end
    tick();
    checks++;
    if (gnt !== 4'b1000 || select !== 2'd3) begin errors++; $display("FAIL early_wrap gnt %b sel %0d want 1000 3", gnt, select); end
    tick(); req = 4'b0000; tick();
    req = 4'b1001; tick();
    checks++;
    if (gnt !== 4'b0001 || select !== 2'd0 || gnt !== m_gnt()) begin
      errors++;
      $display("FAIL early_ptr0 gnt %b sel %0d want 0001 0", gnt, select);
    end
  endtask

  task automatic test_reset_mid_grant();
    rst = 1'b1; req = 4'b0000; tick(); rst = 1'b0;
    req = 4'b0100; tick(); tick();
    rst = 1'b1; req = 4'b0110; tick();
    checks++;
    if (gnt !== 4'b0000 || select !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset gnt %b sel %0d busy %b want 0000 0 0", gnt, select, busy);
    end
    rst = 1'b0; tick();
    checks++;
    if (gnt !== 4'b0010 || select !== 2'd1) begin
      errors++;
      $display("FAIL mid_reset_regrant gnt %b sel %0d want 0010 1", gnt, select);
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    rst = 1'b1; req = 4'b0000; lock = 1'b0; tick(); rst = 1'b0;
    req = 4'b0011; lock = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick();
      checks++;
      if (i > 0 && gnt !== 4'b0001) begin
        errors++;
        $display("FAIL lock_hold cyc %0d gnt %b want 0001", i, gnt);
      end
    end
    lock = 1'b0; tick();
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL lock_release gnt %b want 0000", gnt); end
    tick();
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL lock_next gnt %b want 0010", gnt); end
  endtask
`endif

  task automatic test_random();
    rst = 1'b1; req = 4'b0000; lock = 1'b0; tick(); rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      req  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : req;
      lock = ($urandom_range(0, 7) == 0) ? ~lock : lock;
      rst  = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if (gnt !== m_gnt() || select !== 2'(m_sel) || busy !== (m_cur >= 0)) begin
        errors++;
        $display("FAIL random cyc %0d req %b gnt %b/%b sel %0d/%0d busy %b", i, req, gnt, m_gnt(), select, m_sel, busy);
      end
      checks++;
      if (!$onehot0(gnt) || (gnt != 4'b0000 && !gnt[select]) || busy !== (|gnt)) begin
        errors++;
        $display("FAIL invariant cyc %0d gnt %b sel %0d busy %b", i, gnt, select, busy);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_load();
    test_early_release();
    test_reset_mid_grant();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
